// File: rtl/pio_chaser_master_if.sv
// Avalon-MM signal bundle between the LED chaser master and the interconnect.
interface pio_chaser_master_if #(
  parameter int unsigned ADDR_W = 16
) ();
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/pio_chaser_master.sv
// Avalon-MM initiator that polls the button PIO edge capture and advances a
// one-hot LED pattern on the LED PIO, replacing the CPU-driven chaser loop.
module pio_chaser_master #(
  parameter int unsigned       ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] BTN_BASE    = ADDR_W'(16'h0010),
  parameter logic [ADDR_W-1:0] LED_BASE    = ADDR_W'(16'h0000),
  parameter int unsigned       LED_WIDTH   = 8,
  parameter int unsigned       POLL_CYCLES = 1000,
  localparam int unsigned      POS_W       = $clog2(LED_WIDTH)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                irq_in,
  pio_chaser_master_if.master avm,
  output logic [POS_W-1:0]    led_pos,
  output logic                busy
);

  localparam int unsigned       CNT_W    = $clog2(POLL_CYCLES);
  localparam logic [ADDR_W-1:0] CAP_ADDR = BTN_BASE + ADDR_W'(12);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(POLL_CYCLES - 1);
  localparam logic [POS_W-1:0]  POS_LAST = POS_W'(LED_WIDTH - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RD_CAP,
    S_WR_CLR,
    S_WR_LED
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [POS_W-1:0]  pos_d;
  logic              busy_d;
  logic              done_q, done_d;
  logic              edge_q, edge_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  function automatic logic [31:0] one_hot(input logic [POS_W-1:0] pos);
    return 32'h1 << pos;
  endfunction

  // Each transfer state spends one or more cycles with its command high, then
  // one command-free cycle (done_q) before handing over to the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pos_d   = led_pos;
    done_d  = done_q;
    edge_d  = edge_q;
    read_d  = read_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    if (state_q == S_IDLE) begin
      if (!enable) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST || irq_in) begin
        cnt_d   = '0;
        state_d = S_RD_CAP;
        read_d  = 1'b1;
        addr_d  = CAP_ADDR;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (read_q || write_q) begin
      if (!avm.avm_waitrequest) begin
        read_d  = 1'b0;
        write_d = 1'b0;
        done_d  = 1'b1;
        if (state_q == S_RD_CAP) edge_d = avm.avm_readdata[0];
        if (state_q == S_WR_CLR) pos_d = (led_pos == POS_LAST) ? '0 : led_pos + POS_W'(1);
      end
    end else if (done_q) begin
      done_d = 1'b0;
      case (state_q)
        S_RD_CAP: begin
          if (edge_q) begin
            state_d = S_WR_CLR;
            write_d = 1'b1;
            addr_d  = CAP_ADDR;
            wdata_d = 32'h1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WR_CLR: begin
          state_d = S_WR_LED;
          write_d = 1'b1;
          addr_d  = LED_BASE;
          wdata_d = one_hot(led_pos);
        end
        default: state_d = S_IDLE;
      endcase
    end else begin
      // First INIT cycle after reset: publish the reset LED position.
      write_d = 1'b1;
      addr_d  = LED_BASE;
      wdata_d = one_hot(led_pos);
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      led_pos <= '0;
      busy    <= 1'b1;
      done_q  <= 1'b0;
      edge_q  <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      led_pos <= pos_d;
      busy    <= busy_d;
      done_q  <= done_d;
      edge_q  <= edge_d;
      read_q  <= read_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign avm.avm_address   = addr_q;
  assign avm.avm_read      = read_q;
  assign avm.avm_write     = write_q;
  assign avm.avm_writedata = wdata_q;

endmodule

// File: tb/tb_pio_chaser_master.sv
// Self-checking bench for pio_chaser_master: Avalon slave with random stalls,
// transaction log, and a poll-level reference model of the LED chaser.
module tb_pio_chaser_master;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned LED_W  = 8;
  localparam int unsigned POLL   = 16;
  localparam logic [15:0] BTN    = 16'h0010;
  localparam logic [15:0] LEDA   = 16'h0000;
  localparam logic [15:0] CAP    = 16'h001C;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       irq_in = 1'b0;
  logic [2:0] led_pos;
  logic       busy;

  pio_chaser_master_if #(.ADDR_W(ADDR_W)) bus ();

  pio_chaser_master #(
    .ADDR_W(ADDR_W), .BTN_BASE(BTN), .LED_BASE(LEDA),
    .LED_WIDTH(LED_W), .POLL_CYCLES(POLL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .irq_in(irq_in),
    .avm(bus), .led_pos(led_pos), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] data;
    int          cyc;
  } txn_t;

  txn_t        txq[$];
  txn_t        exp_q[$];
  logic [31:0] rd_vals[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          viol = 0;
  int          model_pos = 0;
  int          stall_min = 0;
  int          stall_max = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Avalon slave: random stall lengths, logs completed transfers, counts protocol breaches.
  int          stall_left = -1;
  bit          prev_stalled = 0;
  bit          prev_done = 0;
  logic [15:0] h_addr;
  logic        h_rd, h_wr;
  logic [31:0] h_data;
  always @(negedge clk) begin
    txn_t t;
    if (!reset_n) begin
      bus.avm_waitrequest = 1'b0;
      bus.avm_readdata    = 32'h0;
      stall_left   = -1;
      prev_stalled = 0;
      prev_done    = 0;
    end else begin
      if (bus.avm_read && bus.avm_write) viol++;
      if ((bus.avm_read || bus.avm_write) && prev_done) viol++;
      if (prev_stalled && (bus.avm_address !== h_addr || bus.avm_read !== h_rd ||
                           bus.avm_write !== h_wr || bus.avm_writedata !== h_data)) viol++;
      if (!(bus.avm_read || bus.avm_write)) begin
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata    = $urandom;
        stall_left   = -1;
        prev_stalled = 0;
        prev_done    = 0;
      end else begin
        if (stall_left < 0) stall_left = $urandom_range(stall_max, stall_min);
        if (stall_left > 0) begin
          stall_left--;
          bus.avm_waitrequest = 1'b1;
          bus.avm_readdata    = $urandom;
          prev_stalled = 1;
          prev_done    = 0;
          h_addr = bus.avm_address; h_rd = bus.avm_read;
          h_wr   = bus.avm_write;   h_data = bus.avm_writedata;
        end else begin
          bus.avm_waitrequest = 1'b0;
          t.wr   = bus.avm_write;
          t.addr = bus.avm_address;
          t.cyc  = cyc;
          if (bus.avm_write) t.data = bus.avm_writedata;
          else t.data = (rd_vals.size() > 0) ? rd_vals.pop_front() : ($urandom & 32'hFFFF_FFFE);
          bus.avm_readdata = t.data;
          txq.push_back(t);
          stall_left   = -1;
          prev_stalled = 0;
          prev_done    = 1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_txns(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && txq.size() < n; i++) tick(1);
    ok = (txq.size() >= n);
  endtask

  // Reference model: one poll reads the capture; a set bit 0 clears it and
  // advances the lit LED by one position, wrapping at LED_W.
  task automatic model_poll(input logic [31:0] v);
    txn_t        t;
    logic [31:0] one;
    one = 32'h1;
    t.cyc = 0;
    t.wr = 0; t.addr = CAP; t.data = v;
    exp_q.push_back(t);
    if (v[0]) begin
      model_pos = (model_pos + 1) % LED_W;
      t.wr = 1; t.addr = CAP; t.data = 32'h1;
      exp_q.push_back(t);
      t.wr = 1; t.addr = LEDA; t.data = one << model_pos;
      exp_q.push_back(t);
    end
  endtask

  task automatic run_polls(input int budget, output bit ok);
    enable = 1'b1;
    wait_txns(exp_q.size(), budget, ok);
    enable = 1'b0;
    tick(4);
  endtask

  task automatic test_reset;
    bit ok;
    int rel;
    reset_n = 1'b0;
    tick(3);
    checks++; if (bus.avm_read !== 1'b0) begin errors++; $display("FAIL rst_read got=%b exp=0", bus.avm_read); end
    checks++; if (bus.avm_write !== 1'b0) begin errors++; $display("FAIL rst_write got=%b exp=0", bus.avm_write); end
    checks++; if (bus.avm_address !== 16'h0) begin errors++; $display("FAIL rst_addr got=%h exp=0", bus.avm_address); end
    checks++; if (bus.avm_writedata !== 32'h0) begin errors++; $display("FAIL rst_wdata got=%h exp=0", bus.avm_writedata); end
    checks++; if (led_pos !== 3'd0) begin errors++; $display("FAIL rst_led_pos got=%0d exp=0", led_pos); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got=%b exp=1", busy); end
    reset_n = 1'b1;
    rel = cyc;
    wait_txns(1, 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL init_timeout got=0 txns exp=1"); end
    if (ok) begin
      checks++;
      if (!txq[0].wr || txq[0].addr !== LEDA || txq[0].data !== 32'h1 || txq[0].cyc != rel + 1) begin
        errors++;
        $display("FAIL init_write got wr=%0b addr=%h data=%h cyc=%0d exp wr=1 addr=0000 data=00000001 cyc=%0d",
                 txq[0].wr, txq[0].addr, txq[0].data, txq[0].cyc, rel + 1);
      end
    end
    repeat (rel + 3 - cyc) tick(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL init_busy_fall got=%b exp=0", busy); end
    txq.delete();
    model_pos = 0;
  endtask

  task automatic test_poll_idle;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      rd_vals.push_back($urandom & 32'hFFFF_FFFE);
      model_poll(rd_vals[i]);
    end
    run_polls(5 * (POLL + 2) + 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL idle_poll_timeout got=%0d exp=4", txq.size()); end
    for (int i = 0; i < txq.size(); i++) begin
      checks++;
      if (txq[i].wr || txq[i].addr !== CAP) begin
        errors++; $display("FAIL idle_poll_read[%0d] got wr=%0b addr=%h exp wr=0 addr=%h", i, txq[i].wr, txq[i].addr, CAP);
      end
      if (i > 0) begin
        checks++;
        if (txq[i].cyc - txq[i-1].cyc != POLL + 2) begin
          errors++; $display("FAIL idle_poll_period[%0d] got=%0d exp=%0d", i, txq[i].cyc - txq[i-1].cyc, POLL + 2);
        end
      end
    end
    checks++; if (led_pos !== 3'(model_pos)) begin errors++; $display("FAIL idle_led_pos got=%0d exp=%0d", led_pos, model_pos); end
    txq.delete(); exp_q.delete(); rd_vals.delete();
  endtask

  task automatic test_stall;
    bit ok;
    stall_min = 3; stall_max = 3; viol = 0;
    rd_vals.push_back($urandom | 32'h1);
    model_poll(rd_vals[0]);
    run_polls(POLL + 60, ok);
    checks++; if (!ok || txq.size() != exp_q.size()) begin errors++; $display("FAIL stall_count got=%0d exp=%0d", txq.size(), exp_q.size()); end
    for (int i = 0; i < txq.size() && i < exp_q.size(); i++) begin
      checks++;
      if (txq[i].wr != exp_q[i].wr || txq[i].addr !== exp_q[i].addr || (txq[i].wr && txq[i].data !== exp_q[i].data)) begin
        errors++; $display("FAIL stall_txn[%0d] got wr=%0b addr=%h data=%h exp wr=%0b addr=%h data=%h",
                           i, txq[i].wr, txq[i].addr, txq[i].data, exp_q[i].wr, exp_q[i].addr, exp_q[i].data);
      end
    end
    checks++; if (viol != 0) begin errors++; $display("FAIL stall_protocol got=%0d violations exp=0", viol); end
    checks++; if (led_pos !== 3'(model_pos)) begin errors++; $display("FAIL stall_led_pos got=%0d exp=%0d", led_pos, model_pos); end
    txq.delete(); exp_q.delete(); rd_vals.delete();
  endtask

  task automatic test_wrap;
    bit ok;
    stall_min = 0; stall_max = 2;
    for (int i = 0; i < 9; i++) begin
      rd_vals.push_back($urandom | 32'h1);
      model_poll(rd_vals[i]);
    end
    run_polls(9 * (POLL + 40), ok);
    checks++; if (!ok || txq.size() != exp_q.size()) begin errors++; $display("FAIL wrap_count got=%0d exp=%0d", txq.size(), exp_q.size()); end
    for (int i = 0; i < txq.size() && i < exp_q.size(); i++) begin
      checks++;
      if (txq[i].wr != exp_q[i].wr || txq[i].addr !== exp_q[i].addr || (txq[i].wr && txq[i].data !== exp_q[i].data)) begin
        errors++; $display("FAIL wrap_txn[%0d] got wr=%0b addr=%h data=%h exp wr=%0b addr=%h data=%h",
                           i, txq[i].wr, txq[i].addr, txq[i].data, exp_q[i].wr, exp_q[i].addr, exp_q[i].data);
      end
    end
    checks++; if (led_pos !== 3'(model_pos)) begin errors++; $display("FAIL wrap_led_pos got=%0d exp=%0d", led_pos, model_pos); end
    txq.delete(); exp_q.delete(); rd_vals.delete();
  endtask

  task automatic test_random;
    bit ok;
    stall_min = 0; stall_max = 4; viol = 0;
    for (int i = 0; i < 12; i++) begin
      rd_vals.push_back($urandom);
      model_poll(rd_vals[i]);
    end
    run_polls(12 * (POLL + 50), ok);
    checks++; if (!ok || txq.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", txq.size(), exp_q.size()); end
    for (int i = 0; i < txq.size() && i < exp_q.size(); i++) begin
      checks++;
      if (txq[i].wr != exp_q[i].wr || txq[i].addr !== exp_q[i].addr || (txq[i].wr && txq[i].data !== exp_q[i].data)) begin
        errors++; $display("FAIL rand_txn[%0d] got wr=%0b addr=%h data=%h exp wr=%0b addr=%h data=%h",
                           i, txq[i].wr, txq[i].addr, txq[i].data, exp_q[i].wr, exp_q[i].addr, exp_q[i].data);
      end
    end
    checks++; if (viol != 0) begin errors++; $display("FAIL rand_protocol got=%0d violations exp=0", viol); end
    checks++; if (led_pos !== 3'(model_pos)) begin errors++; $display("FAIL rand_led_pos got=%0d exp=%0d", led_pos, model_pos); end
    txq.delete(); exp_q.delete(); rd_vals.delete();
  endtask

  task automatic test_irq;
    bit ok;
    int ci;
    stall_min = 0; stall_max = 0;
    enable = 1'b1;
    tick(5);
    irq_in = 1'b1;
    ci = cyc;
    tick(1);
    irq_in = 1'b0;
    wait_txns(1, 5, ok);
    enable = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL irq_timeout got=0 txns exp=1"); end
    if (ok) begin
      checks++;
      if (txq[0].wr || txq[0].addr !== CAP || txq[0].cyc != ci + 1) begin
        errors++; $display("FAIL irq_read got wr=%0b addr=%h cyc=%0d exp wr=0 addr=%h cyc=%0d",
                           txq[0].wr, txq[0].addr, txq[0].cyc, CAP, ci + 1);
      end
    end
    tick(4);
    txq.delete();
    irq_in = 1'b1;
    tick(3 * POLL);
    irq_in = 1'b0;
    checks++; if (txq.size() != 0) begin errors++; $display("FAIL irq_disabled got=%0d txns exp=0", txq.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL irq_disabled_busy got=%b exp=0", busy); end
    txq.delete(); rd_vals.delete();
  endtask

  task automatic test_reset_mid;
    bit ok;
    bit found;
    stall_min = 40; stall_max = 40;
    rd_vals.push_back(32'h1);
    enable = 1'b1;
    irq_in = 1'b1;
    tick(1);
    irq_in = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick(1);
      found = bus.avm_write && bus.avm_address == CAP && bus.avm_waitrequest;
    end
    checks++; if (!found) begin errors++; $display("FAIL mid_clr_stall got=0 exp=1"); end
    tick(2);
    reset_n = 1'b0;
    #1;
    checks++; if (bus.avm_write !== 1'b0) begin errors++; $display("FAIL mid_rst_write got=%b exp=0", bus.avm_write); end
    checks++; if (led_pos !== 3'd0) begin errors++; $display("FAIL mid_rst_led_pos got=%0d exp=0", led_pos); end
    stall_min = 0; stall_max = 0;
    enable = 1'b0;
    tick(2);
    txq.delete(); rd_vals.delete();
    reset_n = 1'b1;
    model_pos = 0;
    wait_txns(1, 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_init_timeout got=0 txns exp=1"); end
    if (ok) begin
      checks++;
      if (!txq[0].wr || txq[0].addr !== LEDA || txq[0].data !== 32'h1) begin
        errors++; $display("FAIL mid_init_write got wr=%0b addr=%h data=%h exp wr=1 addr=0000 data=00000001",
                           txq[0].wr, txq[0].addr, txq[0].data);
      end
    end
    tick(3);
    checks++; if (led_pos !== 3'(model_pos)) begin errors++; $display("FAIL mid_led_pos got=%0d exp=%0d", led_pos, model_pos); end
    checks++; if (txq.size() != 1) begin errors++; $display("FAIL mid_extra_txns got=%0d exp=1", txq.size()); end
  endtask

  initial begin
    test_reset();
    test_poll_idle();
    test_stall();
    test_wrap();
    test_random();
    test_irq();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
